// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM control FSM.
// Holds the state enum, op-field and datapath mux-select encodings, and the control vector.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_BASEWB,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BRANCH
    } state_t;

    localparam logic [1:0] OP_DP    = 2'b00;
    localparam logic [1:0] OP_MEM   = 2'b01;
    localparam logic [1:0] OP_BR    = 2'b10;
    localparam logic [1:0] OP_UNDEF = 2'b11;

    localparam logic [1:0] SRCA_RN    = 2'b00;
    localparam logic [1:0] SRCA_PC    = 2'b01;

    localparam logic [1:0] SRCB_RM    = 2'b00;
    localparam logic [1:0] IMM_SEL    = 2'b01;
    localparam logic [1:0] PC_INC_SEL = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    localparam logic [1:0] REGSRC_BR  = 2'b01;
    localparam logic [1:0] REGSRC_STR = 2'b10;

    typedef struct packed {
        logic       ir_w;
        logic       pc_w;
        logic       branch;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       alu_op;
        logic [1:0] result_src;
        logic [1:0] imm_src;
        logic [1:0] reg_src;
        logic       reg_w;
        logic       mem_w;
        logic       post_idx;
        logic       undef;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Bundle between the control FSM (master) and the instruction register / datapath (slave).
// The master consumes the decoded instruction fields and memory handshake, and drives every control line.
interface multicycle_control_fsm_if;

    logic [1:0] op;
    logic [5:0] funct;
    logic       cond_ex;
    logic       mem_ready;

    logic       ir_w;
    logic       pc_w;
    logic       branch;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_op;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic       reg_w;
    logic       mem_w;
    logic       post_idx;
    logic       undef;

    modport master (
        input  op, funct, cond_ex, mem_ready,
        output ir_w, pc_w, branch, adr_src, alu_src_a, alu_src_b, alu_op,
               result_src, imm_src, reg_src, reg_w, mem_w, post_idx, undef
    );

    modport slave (
        output op, funct, cond_ex, mem_ready,
        input  ir_w, pc_w, branch, adr_src, alu_src_a, alu_src_b, alu_op,
               result_src, imm_src, reg_src, reg_w, mem_w, post_idx, undef
    );

endinterface

// File: rtl/mc_output_decode.sv
// Combinational state -> control-vector lookup for the multicycle control FSM.
// A few lines are qualified by live inputs (fetch handshake, store source, undefined op).
module mc_output_decode
    import arm_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [1:0] op,
    input  logic       reg_off,
    input  logic       is_load,
    input  logic       cond_ex,
    input  logic       mem_ready,
    input  logic       post_idx,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = PC_INC_SEL;
                ctrl.result_src = RES_ALU;
                ctrl.ir_w       = mem_ready;
                ctrl.pc_w       = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = PC_INC_SEL;
                ctrl.result_src = RES_ALU;
                case (op)
                    OP_MEM: begin
                        ctrl.imm_src = IMM_MEM;
                        ctrl.reg_src = is_load ? 2'b00 : REGSRC_STR;
                    end
                    OP_BR: begin
                        ctrl.imm_src = IMM_BR;
                        ctrl.reg_src = REGSRC_BR;
                    end
                    default: ;
                endcase
                // A squashed instruction must not raise undef either.
                ctrl.undef = cond_ex && (op == OP_UNDEF);
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RN;
                ctrl.alu_src_b = reg_off ? SRCB_RM : IMM_SEL;
                ctrl.imm_src   = IMM_MEM;
                ctrl.post_idx  = post_idx;
            end
            S_MEMRD: begin
                ctrl.adr_src  = 1'b1;
                ctrl.post_idx = post_idx;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_RDATA;
                ctrl.reg_w      = 1'b1;
                ctrl.post_idx   = post_idx;
            end
            S_MEMWR: begin
                ctrl.adr_src  = 1'b1;
                ctrl.reg_src  = REGSRC_STR;
                ctrl.mem_w    = 1'b1;
                ctrl.post_idx = post_idx;
            end
            S_BASEWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_w      = 1'b1;
                ctrl.post_idx   = post_idx;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = SRCA_RN;
                ctrl.alu_src_b = SRCB_RM;
                ctrl.alu_op    = 1'b1;
                ctrl.imm_src   = IMM_DP;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = SRCA_RN;
                ctrl.alu_src_b = IMM_SEL;
                ctrl.alu_op    = 1'b1;
                ctrl.imm_src   = IMM_DP;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_w      = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = SRCA_RN;
                ctrl.reg_src    = REGSRC_BR;
                ctrl.alu_src_b  = IMM_SEL;
                ctrl.imm_src    = IMM_BR;
                ctrl.result_src = RES_ALU;
                ctrl.branch     = 1'b1;
                ctrl.pc_w       = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main sequencing controller of the multicycle ARM core: steps each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath controls.
module multicycle_control_fsm
    import arm_ctrl_pkg::*;
(
    input logic                      clk,
    input logic                      reset_n,
    multicycle_control_fsm_if.master bus
);

    state_t state;
    state_t next_state;
    logic   post_idx_q;
    ctrl_t  ctrl;
    ctrl_t  ctrl_out;
    logic   unused_funct_bits;

    assign unused_funct_bits = ^bus.funct[3:1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_FETCH;
            post_idx_q <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_DECODE)
                post_idx_q <= ~bus.funct[4];
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:  if (bus.mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                if (!bus.cond_ex) begin
                    next_state = S_FETCH;
                end else begin
                    case (bus.op)
                        OP_DP:   next_state = bus.funct[5] ? S_EXEC_I : S_EXEC_R;
                        OP_MEM:  next_state = S_MEMADR;
                        OP_BR:   next_state = S_BRANCH;
                        default: next_state = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: next_state = bus.funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (bus.mem_ready) next_state = S_MEMWB;
            S_MEMWB:  next_state = post_idx_q ? S_BASEWB : S_FETCH;
            S_MEMWR:  if (bus.mem_ready) next_state = post_idx_q ? S_BASEWB : S_FETCH;
            S_EXEC_R: next_state = S_ALUWB;
            S_EXEC_I: next_state = S_ALUWB;
            default:  next_state = S_FETCH;
        endcase
    end

    mc_output_decode u_output_decode (
        .state     (state),
        .op        (bus.op),
        .reg_off   (bus.funct[5]),
        .is_load   (bus.funct[0]),
        .cond_ex   (bus.cond_ex),
        .mem_ready (bus.mem_ready),
        .post_idx  (post_idx_q),
        .ctrl      (ctrl)
    );

    // Outputs drop to zero the moment reset asserts so no write can leak out mid-instruction.
    always_comb begin
        ctrl_out = reset_n ? ctrl : '0;
    end

    assign bus.ir_w       = ctrl_out.ir_w;
    assign bus.pc_w       = ctrl_out.pc_w;
    assign bus.branch     = ctrl_out.branch;
    assign bus.adr_src    = ctrl_out.adr_src;
    assign bus.alu_src_a  = ctrl_out.alu_src_a;
    assign bus.alu_src_b  = ctrl_out.alu_src_b;
    assign bus.alu_op     = ctrl_out.alu_op;
    assign bus.result_src = ctrl_out.result_src;
    assign bus.imm_src    = ctrl_out.imm_src;
    assign bus.reg_src    = ctrl_out.reg_src;
    assign bus.reg_w      = ctrl_out.reg_w;
    assign bus.mem_w      = ctrl_out.mem_w;
    assign bus.post_idx   = ctrl_out.post_idx;
    assign bus.undef      = ctrl_out.undef;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: per-cycle stimulus and expected control vectors
// are queued per scenario, then replayed and compared one cycle at a time.
module tb_multicycle_control_fsm;

    typedef struct packed {
        logic       ir_w;
        logic       pc_w;
        logic       branch;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       alu_op;
        logic [1:0] result_src;
        logic [1:0] imm_src;
        logic [1:0] reg_src;
        logic       reg_w;
        logic       mem_w;
        logic       post_idx;
        logic       undef;
    } exp_t;

    typedef struct {
        string      tag;
        logic [1:0] op;
        logic [5:0] funct;
        logic       cond_ex;
        logic       mem_ready;
        exp_t       exp;
    } sb_entry_t;

    localparam exp_t X_ZERO        = '0;
    localparam exp_t X_FETCH_GO    = '{ir_w:1'b1, pc_w:1'b1, alu_src_a:2'b01, alu_src_b:2'b10, result_src:2'b10, default:'0};
    localparam exp_t X_FETCH_WAIT  = '{alu_src_a:2'b01, alu_src_b:2'b10, result_src:2'b10, default:'0};
    localparam exp_t X_DECODE_DP   = '{alu_src_a:2'b01, alu_src_b:2'b10, result_src:2'b10, default:'0};
    localparam exp_t X_DECODE_UND  = '{alu_src_a:2'b01, alu_src_b:2'b10, result_src:2'b10, undef:1'b1, default:'0};
    localparam exp_t X_DECODE_LDR  = '{alu_src_a:2'b01, alu_src_b:2'b10, result_src:2'b10, imm_src:2'b01, default:'0};
    localparam exp_t X_DECODE_STR  = '{alu_src_a:2'b01, alu_src_b:2'b10, result_src:2'b10, imm_src:2'b01, reg_src:2'b10, default:'0};
    localparam exp_t X_DECODE_BR   = '{alu_src_a:2'b01, alu_src_b:2'b10, result_src:2'b10, imm_src:2'b10, reg_src:2'b01, default:'0};
    localparam exp_t X_EXEC_I      = '{alu_src_b:2'b01, alu_op:1'b1, default:'0};
    localparam exp_t X_EXEC_R      = '{alu_op:1'b1, default:'0};
    localparam exp_t X_ALUWB       = '{reg_w:1'b1, default:'0};
    localparam exp_t X_MEMADR_IP   = '{alu_src_b:2'b01, imm_src:2'b01, post_idx:1'b1, default:'0};
    localparam exp_t X_MEMADR_I    = '{alu_src_b:2'b01, imm_src:2'b01, default:'0};
    localparam exp_t X_MEMADR_R    = '{imm_src:2'b01, default:'0};
    localparam exp_t X_MEMRD_P     = '{adr_src:1'b1, post_idx:1'b1, default:'0};
    localparam exp_t X_MEMRD       = '{adr_src:1'b1, default:'0};
    localparam exp_t X_MEMWB_P     = '{result_src:2'b01, reg_w:1'b1, post_idx:1'b1, default:'0};
    localparam exp_t X_MEMWB       = '{result_src:2'b01, reg_w:1'b1, default:'0};
    localparam exp_t X_BASEWB_P    = '{reg_w:1'b1, post_idx:1'b1, default:'0};
    localparam exp_t X_MEMWR       = '{adr_src:1'b1, reg_src:2'b10, mem_w:1'b1, default:'0};
    localparam exp_t X_BRANCH      = '{pc_w:1'b1, branch:1'b1, alu_src_b:2'b01, result_src:2'b10, imm_src:2'b10, reg_src:2'b01, default:'0};

    logic clk;
    logic reset_n;
    int   compared;
    int   mismatched;
    sb_entry_t sb_q[$];

    multicycle_control_fsm_if bus();

    multicycle_control_fsm dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic exp_t sample_outputs();
        exp_t s;
        s.ir_w       = bus.ir_w;
        s.pc_w       = bus.pc_w;
        s.branch     = bus.branch;
        s.adr_src    = bus.adr_src;
        s.alu_src_a  = bus.alu_src_a;
        s.alu_src_b  = bus.alu_src_b;
        s.alu_op     = bus.alu_op;
        s.result_src = bus.result_src;
        s.imm_src    = bus.imm_src;
        s.reg_src    = bus.reg_src;
        s.reg_w      = bus.reg_w;
        s.mem_w      = bus.mem_w;
        s.post_idx   = bus.post_idx;
        s.undef      = bus.undef;
        return s;
    endfunction

    task automatic push(input string tag, input logic [1:0] op, input logic [5:0] funct,
                        input logic cond_ex, input logic mem_ready, input exp_t exp);
        sb_entry_t e;
        e.tag = tag; e.op = op; e.funct = funct;
        e.cond_ex = cond_ex; e.mem_ready = mem_ready; e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t obs;
        @(negedge clk);
        bus.mem_ready = 1'b1;
        #1;
        obs = sample_outputs();
        compared++;
        if (obs !== X_ZERO) begin
            mismatched++;
            $display("[TB] FAIL reset_hold: got %b required %b", obs, X_ZERO);
        end
        @(negedge clk);
        reset_n = 1'b1;
        bus.mem_ready = 1'b0;
        #1;
        obs = sample_outputs();
        compared++;
        if (obs !== X_FETCH_WAIT) begin
            mismatched++;
            $display("[TB] FAIL reset_release_fetch: got %b required %b", obs, X_FETCH_WAIT);
        end
    endtask

    task automatic test_dp_imm();
        sb_entry_t e;
        exp_t obs;
        push("dp_fetch",  2'b00, 6'b100000, 1'b1, 1'b1, X_FETCH_GO);
        push("dp_decode", 2'b00, 6'b100000, 1'b1, 1'b1, X_DECODE_DP);
        push("dp_exec_i", 2'b00, 6'b100000, 1'b1, 1'b1, X_EXEC_I);
        push("dp_aluwb",  2'b00, 6'b100000, 1'b1, 1'b1, X_ALUWB);
        push("dp_refetch", 2'b00, 6'b100000, 1'b1, 1'b0, X_FETCH_WAIT);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(negedge clk);
            bus.op = e.op; bus.funct = e.funct; bus.cond_ex = e.cond_ex; bus.mem_ready = e.mem_ready;
            #1;
            obs = sample_outputs();
            compared++;
            if (obs !== e.exp) begin
                mismatched++;
                $display("[TB] FAIL %s: got %b required %b", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic test_ldr_post();
        sb_entry_t e;
        exp_t obs;
        push("ldrp_fetch",   2'b01, 6'b000001, 1'b1, 1'b1, X_FETCH_GO);
        push("ldrp_decode",  2'b01, 6'b000001, 1'b1, 1'b1, X_DECODE_LDR);
        push("ldrp_memadr",  2'b01, 6'b000001, 1'b1, 1'b1, X_MEMADR_IP);
        push("ldrp_memrd_w", 2'b01, 6'b000001, 1'b1, 1'b0, X_MEMRD_P);
        push("ldrp_memrd",   2'b01, 6'b000001, 1'b1, 1'b1, X_MEMRD_P);
        push("ldrp_memwb",   2'b01, 6'b000001, 1'b1, 1'b1, X_MEMWB_P);
        push("ldrp_basewb",  2'b01, 6'b000001, 1'b1, 1'b1, X_BASEWB_P);
        push("ldrp_refetch", 2'b01, 6'b000001, 1'b1, 1'b0, X_FETCH_WAIT);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(negedge clk);
            bus.op = e.op; bus.funct = e.funct; bus.cond_ex = e.cond_ex; bus.mem_ready = e.mem_ready;
            #1;
            obs = sample_outputs();
            compared++;
            if (obs !== e.exp) begin
                mismatched++;
                $display("[TB] FAIL %s: got %b required %b", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic test_str_wait();
        sb_entry_t e;
        exp_t obs;
        push("str_fetch",  2'b01, 6'b110000, 1'b1, 1'b1, X_FETCH_GO);
        push("str_decode", 2'b01, 6'b110000, 1'b1, 1'b1, X_DECODE_STR);
        push("str_memadr", 2'b01, 6'b110000, 1'b1, 1'b1, X_MEMADR_R);
        for (int i = 0; i < 3; i++)
            push($sformatf("str_memwr_wait%0d", i), 2'b01, 6'b110000, 1'b1, 1'b0, X_MEMWR);
        push("str_memwr_done", 2'b01, 6'b110000, 1'b1, 1'b1, X_MEMWR);
        push("str_refetch",    2'b01, 6'b110000, 1'b1, 1'b0, X_FETCH_WAIT);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(negedge clk);
            bus.op = e.op; bus.funct = e.funct; bus.cond_ex = e.cond_ex; bus.mem_ready = e.mem_ready;
            #1;
            obs = sample_outputs();
            compared++;
            if (obs !== e.exp) begin
                mismatched++;
                $display("[TB] FAIL %s: got %b required %b", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic test_cond_fail_undef();
        sb_entry_t e;
        exp_t obs;
        push("cf_dp_fetch",   2'b00, 6'b000000, 1'b0, 1'b1, X_FETCH_GO);
        push("cf_dp_decode",  2'b00, 6'b000000, 1'b0, 1'b1, X_DECODE_DP);
        push("cf_dp_refetch", 2'b00, 6'b000000, 1'b0, 1'b0, X_FETCH_WAIT);
        push("cf_br_fetch",   2'b10, 6'b000000, 1'b0, 1'b1, X_FETCH_GO);
        push("cf_br_decode",  2'b10, 6'b000000, 1'b0, 1'b1, X_DECODE_BR);
        push("cf_br_refetch", 2'b10, 6'b000000, 1'b0, 1'b0, X_FETCH_WAIT);
        push("und_fetch",     2'b11, 6'b000000, 1'b1, 1'b1, X_FETCH_GO);
        push("und_decode",    2'b11, 6'b000000, 1'b1, 1'b1, X_DECODE_UND);
        push("und_after",     2'b11, 6'b000000, 1'b1, 1'b1, X_FETCH_GO);
        push("und_next_dec",  2'b00, 6'b000000, 1'b0, 1'b1, X_DECODE_DP);
        push("und_refetch",   2'b00, 6'b000000, 1'b0, 1'b0, X_FETCH_WAIT);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(negedge clk);
            bus.op = e.op; bus.funct = e.funct; bus.cond_ex = e.cond_ex; bus.mem_ready = e.mem_ready;
            #1;
            obs = sample_outputs();
            compared++;
            if (obs !== e.exp) begin
                mismatched++;
                $display("[TB] FAIL %s: got %b required %b", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic test_branch();
        sb_entry_t e;
        exp_t obs;
        push("br_stall0",  2'b10, 6'b000000, 1'b1, 1'b0, X_FETCH_WAIT);
        push("br_stall1",  2'b10, 6'b000000, 1'b1, 1'b0, X_FETCH_WAIT);
        push("br_fetch",   2'b10, 6'b000000, 1'b1, 1'b1, X_FETCH_GO);
        push("br_decode",  2'b10, 6'b000000, 1'b1, 1'b1, X_DECODE_BR);
        push("br_branch",  2'b10, 6'b000000, 1'b1, 1'b1, X_BRANCH);
        push("br_refetch", 2'b10, 6'b000000, 1'b1, 1'b0, X_FETCH_WAIT);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(negedge clk);
            bus.op = e.op; bus.funct = e.funct; bus.cond_ex = e.cond_ex; bus.mem_ready = e.mem_ready;
            #1;
            obs = sample_outputs();
            compared++;
            if (obs !== e.exp) begin
                mismatched++;
                $display("[TB] FAIL %s: got %b required %b", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        sb_entry_t e;
        exp_t obs;
        push("b2b_dp_fetch",   2'b00, 6'b000000, 1'b1, 1'b1, X_FETCH_GO);
        push("b2b_dp_decode",  2'b00, 6'b000000, 1'b1, 1'b1, X_DECODE_DP);
        push("b2b_dp_exec_r",  2'b00, 6'b000000, 1'b1, 1'b1, X_EXEC_R);
        push("b2b_dp_aluwb",   2'b00, 6'b000000, 1'b1, 1'b1, X_ALUWB);
        push("b2b_ld_fetch",   2'b01, 6'b010001, 1'b1, 1'b1, X_FETCH_GO);
        push("b2b_ld_decode",  2'b01, 6'b010001, 1'b1, 1'b1, X_DECODE_LDR);
        push("b2b_ld_memadr",  2'b01, 6'b010001, 1'b1, 1'b1, X_MEMADR_I);
        push("b2b_ld_memrd",   2'b01, 6'b010001, 1'b1, 1'b1, X_MEMRD);
        push("b2b_ld_memwb",   2'b01, 6'b010001, 1'b1, 1'b1, X_MEMWB);
        push("b2b_ld_refetch", 2'b01, 6'b010001, 1'b1, 1'b0, X_FETCH_WAIT);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(negedge clk);
            bus.op = e.op; bus.funct = e.funct; bus.cond_ex = e.cond_ex; bus.mem_ready = e.mem_ready;
            #1;
            obs = sample_outputs();
            compared++;
            if (obs !== e.exp) begin
                mismatched++;
                $display("[TB] FAIL %s: got %b required %b", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic test_reset_abort();
        sb_entry_t e;
        exp_t obs;
        push("abort_fetch",  2'b01, 6'b110000, 1'b1, 1'b1, X_FETCH_GO);
        push("abort_decode", 2'b01, 6'b110000, 1'b1, 1'b1, X_DECODE_STR);
        push("abort_memadr", 2'b01, 6'b110000, 1'b1, 1'b1, X_MEMADR_R);
        push("abort_memwr",  2'b01, 6'b110000, 1'b1, 1'b0, X_MEMWR);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(negedge clk);
            bus.op = e.op; bus.funct = e.funct; bus.cond_ex = e.cond_ex; bus.mem_ready = e.mem_ready;
            #1;
            obs = sample_outputs();
            compared++;
            if (obs !== e.exp) begin
                mismatched++;
                $display("[TB] FAIL %s: got %b required %b", e.tag, obs, e.exp);
            end
        end
        #2;
        reset_n = 1'b0;
        #1;
        obs = sample_outputs();
        compared++;
        if (obs !== X_ZERO) begin
            mismatched++;
            $display("[TB] FAIL abort_async: got %b required %b", obs, X_ZERO);
        end
        @(posedge clk);
        #1;
        obs = sample_outputs();
        compared++;
        if (obs !== X_ZERO) begin
            mismatched++;
            $display("[TB] FAIL abort_held: got %b required %b", obs, X_ZERO);
        end
        @(negedge clk);
        reset_n = 1'b1;
        bus.mem_ready = 1'b0;
        #1;
        obs = sample_outputs();
        compared++;
        if (obs !== X_FETCH_WAIT) begin
            mismatched++;
            $display("[TB] FAIL abort_release: got %b required %b", obs, X_FETCH_WAIT);
        end
        @(negedge clk);
        #1;
        obs = sample_outputs();
        compared++;
        if (obs !== X_FETCH_WAIT) begin
            mismatched++;
            $display("[TB] FAIL abort_fetch_stays: got %b required %b", obs, X_FETCH_WAIT);
        end
    endtask

    initial begin
        compared      = 0;
        mismatched    = 0;
        reset_n       = 1'b0;
        bus.op        = 2'b00;
        bus.funct     = 6'b000000;
        bus.cond_ex   = 1'b0;
        bus.mem_ready = 1'b0;

        test_reset();
        test_dp_imm();
        test_ldr_post();
        test_str_wait();
        test_cond_fail_undef();
        test_branch();
        test_back_to_back();
        test_reset_abort();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
